// File: rtl/multi_player_clock.sv
// N-player chess-clock countdown core: BCD times per player, pause with preserved
// prescaler phase, per-player expiry flags. Optional Fischer increment via INCREMENT_EN.
module multi_player_clock #(
    parameter int N_PLAYERS = 2,
    parameter int TICK_DIV  = 1000,
    parameter int INC_SEC   = 5
) (
    input  logic                   CLK,
    input  logic                   CLR,
    input  logic                   CE,
    input  logic                   SELECT,
    input  logic                   STOP,
    input  logic                   LOAD,
    input  logic [6:0]             preset_min,
    input  logic [5:0]             preset_sec,
    output logic [2:0]             active,
    output logic [16*N_PLAYERS-1:0] digits,
    output logic [N_PLAYERS-1:0]   flag,
    output logic                   running,
    output logic                   END
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

    if (N_PLAYERS < 2 || N_PLAYERS > 8) begin : g_bad_players
        $error("N_PLAYERS must be in 2..8");
    end
    if (TICK_DIV < 2) begin : g_bad_div
        $error("TICK_DIV must be at least 2");
    end
    if (INC_SEC < 0 || INC_SEC > 59) begin : g_bad_inc
        $error("INC_SEC must be in 0..59");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t          state, state_d;
    logic [15:0]     times [N_PLAYERS];
    logic [PW-1:0]   pre;
    logic [AW-1:0]   act;
    logic [AW-1:0]   next_act;
    logic [15:0]     cur;
    logic            tick;
    logic [6:0]      pm;
    logic [5:0]      ps;
    logic [15:0]     preset_bcd;

    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [15:0] dec_bcd(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = t;
        if (su != 4'd0) su = su - 4'd1;
        else begin
            su = 4'd9;
            if (st != 4'd0) st = st - 4'd1;
            else begin
                st = 4'd5;
                if (mu != 4'd0) mu = mu - 4'd1;
                else begin
                    mu = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

`ifdef INCREMENT_EN
    function automatic logic [15:0] inc_bcd(input logic [15:0] t);
        logic [6:0] m, s;
        m = 7'(t[15:12]) * 7'd10 + 7'(t[11:8]);
        s = 7'(t[7:4]) * 7'd10 + 7'(t[3:0]) + 7'(INC_SEC);
        if (s >= 7'd60) begin
            s = s - 7'd60;
            m = m + 7'd1;
        end
        if (m > 7'd99) return 16'h9959;
        return {bin2bcd(m), bin2bcd(s)};
    endfunction
`endif

    assign pm         = (preset_min > 7'd99) ? 7'd99 : preset_min;
    assign ps         = (preset_sec > 6'd59) ? 6'd59 : preset_sec;
    assign preset_bcd = {bin2bcd(pm), bin2bcd({1'b0, ps})};
    assign cur        = times[act];
    assign tick       = (pre == PW'(TICK_DIV - 1));
    assign next_act   = (act == AW'(N_PLAYERS - 1)) ? '0 : act + 1'b1;
    assign active     = 3'(act);

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_digits
        assign digits[16*g +: 16] = times[g];
    end

    always_ff @(posedge CLK) begin
        if (CLR) state <= S_IDLE;
        else if (CE) state <= state_d;
    end

    // Zero-time check ranks with the tick: STOP and SELECT take precedence.
    always_comb begin
        state_d = state;
        if (LOAD) state_d = S_IDLE;
        else begin
            case (state)
                S_IDLE:  if (SELECT) state_d = S_RUN;
                S_RUN: begin
                    if (STOP) state_d = S_PAUSE;
                    else if (!SELECT && (cur == 16'h0000 || (tick && cur == 16'h0001)))
                        state_d = S_DONE;
                end
                S_PAUSE: if (STOP) state_d = S_RUN;
                default: ;
            endcase
        end
    end

    always_comb begin
        running = (state == S_RUN);
        END     = (state == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int unsigned p = 0; p < N_PLAYERS; p++) times[p] <= '0;
            flag <= '0;
            act  <= '0;
            pre  <= '0;
        end else if (CE) begin
            if (LOAD) begin
                for (int unsigned p = 0; p < N_PLAYERS; p++) times[p] <= preset_bcd;
                flag <= '0;
                act  <= '0;
                pre  <= '0;
            end else if (state == S_IDLE) begin
                if (SELECT) pre <= '0;
            end else if (state == S_RUN && !STOP) begin
                if (SELECT) begin
                    act <= next_act;
                    pre <= '0;
`ifdef INCREMENT_EN
                    times[act] <= inc_bcd(cur);
`endif
                end else if (cur == 16'h0000) begin
                    flag[act] <= 1'b1;
                end else begin
                    pre <= tick ? '0 : pre + 1'b1;
                    if (tick) begin
                        times[act] <= dec_bcd(cur);
                        if (cur == 16'h0001) flag[act] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/multi_player_clock.md
# multi_player_clock

Parametrised N-player countdown core for the chess-clock design. It generalises the existing two-timer, switch, prescaler and overflow-handler arrangement into one block. The block adds:
- a configurable player count,
- a runtime-loadable preset time,
- pause/resume that preserves the sub-second phase,
- per-player expiry flags,
- an optional Fischer increment.

It drives the existing 7-segment decoders, one decoder per player, through BCD digit outputs.

## Interface
Parameters:
- N_PLAYERS, 2, number of players (2..8).
- TICK_DIV, 1000, CE-qualified cycles per one-second tick (≥2).
- INC_SEC, 5, increment in seconds (0..59). Used only with INCREMENT_EN.

Ports:
- CLK  in  1  clock.
- CLR  in  1  reset; synchronous, active-high.
- CE  in  1  clock enable. While low, all state holds and all command inputs are ignored.
- SELECT  in  1  one-cycle pulse: end the current player's turn.
- STOP  in  1  one-cycle pulse: toggle pause.
- LOAD  in  1  one-cycle pulse: load the preset into all players.
- preset_min  in  7  preset minutes, binary. Values >99 clamp to 99.
- preset_sec  in  6  preset seconds, binary. Values >59 clamp to 59.
- active  out  3  index of the player whose clock is running.
- digits  out  16*N_PLAYERS  BCD time. Player p occupies [16p+15:16p] as {min_tens, min_units, sec_tens, sec_units}.
- flag  out  N_PLAYERS  per-player "time expired".
- running  out  1  high in the RUN state.
- END  out  1  high in the DONE state.

## Operation
- States: IDLE, RUN, PAUSE, DONE. An internal prescaler counts 0..TICK_DIV-1. A tick occurs on a CE cycle with the count at TICK_DIV-1; the count then wraps to 0.
- Reset (CLR): state IDLE; all digits 0; active 0; flag 0; running 0; END 0; prescaler 0.
- LOAD (any state):
  - every player receives the clamped preset, converted to BCD;
  - flag cleared; active 0; prescaler 0; state IDLE.
- IDLE:
  - SELECT → RUN, with active unchanged and prescaler 0.
  - STOP is ignored.
- RUN:
  - The prescaler advances on each CE cycle.
  - On a tick, the active player's time decrements by 1 s using BCD borrow: sec_units 0→9 borrows from sec_tens; sec_tens 0→5 borrows from min_units; min_units 0→9 borrows from min_tens.
  - If the decrement yields 00:00: flag[active] set, state → DONE.
  - If the active time is already 00:00 (zero preset), flag[active] is set and the state goes to DONE on the first CE cycle in RUN.
  - SELECT: active ← (active+1) mod N_PLAYERS; prescaler ← 0.
  - STOP → PAUSE; the prescaler value is retained.
- PAUSE:
  - The prescaler and all times hold.
  - STOP → RUN; counting resumes from the retained prescaler value.
  - SELECT is ignored.
- DONE:
  - Digits and flags are frozen.
  - SELECT and STOP are ignored.
  - Only LOAD or CLR exits.
- Priority within one CE cycle: CLR > LOAD > STOP > SELECT > tick.
  - SELECT with a tick: the tick is discarded; the outgoing player is not decremented.
  - STOP with SELECT: only the pause takes effect.
- Only the active player's digits ever change in RUN, apart from the increment.

## Timing
- All outputs are registered. Every effect is visible on the clock edge that samples the command or tick; no combinational path runs from input to output.
- SELECT → active changes 1 cycle later.
- Tick → digits update 1 cycle later. flag, END and the drop of running update on the same edge as the final decrement.
- Time from RUN entry to the first tick is exactly TICK_DIV CE cycles. After SELECT, the next tick is also exactly TICK_DIV CE cycles away.
- CE low stretches all timing; no state advances.

## Configuration
- INCREMENT_EN defined:
  - On SELECT in RUN, the outgoing player gains INC_SEC seconds, in the same cycle as the turn pass.
  - The addition is BCD with carry (sec > 59 carries into minutes) and saturates at 99:59.
  - The increment is not applied on the IDLE→RUN SELECT or in DONE.
- INCREMENT_EN undefined: no increment logic is built and INC_SEC is unused.

## Test plan
- Reset: assert CLR for 2 cycles with CE=1 → all digits 0, active 0, flag 0, running 0, END 0.
- Countdown borrow (N=2, TICK_DIV=4):
  - LOAD 1:05, SELECT, 20 CE cycles → player0 digits {0,1,0,0}, player1 {0,1,0,5}.
  - 4 more cycles → player0 {0,0,5,9}.
- Expiry: LOAD 0:02, SELECT, 8 CE cycles → flag=2'b01, END=1, running=0. A further SELECT leaves active=0 and the digits at {0,0,0,0}.
- Increment (INCREMENT_EN, INC_SEC=5):
  - LOAD 0:58, SELECT, 4 cycles → player0 0:57.
  - SELECT → player0 1:02, active=1.
  - Without the macro, player0 stays at 0:57.
- Pause phase: after RUN for 2 cycles, STOP, hold 10 cycles, STOP → the digits do not change while paused, and the first tick occurs exactly 2 cycles after resume.
- Rotation and priority (N_PLAYERS=3):
  - Three SELECTs from active 0 → 1, 2, 0.
  - SELECT and STOP in the same cycle → PAUSE with active unchanged.
  - SELECT coinciding with a tick → no decrement of the outgoing player.
